// File: rtl/vcm_focus_writer.sv
// Writes one 10-bit lens position to a DW9714-class VCM driver over the camera
// I2C lines, and owns the bus (VCM_RELAESE=0) for the duration of the frame.
`timescale 1ns/1ps
module vcm_focus_writer #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [6:0]  VCM_ADDR = 7'h0C,
  parameter logic [3:0]  SLEW     = 4'h0
) (
  input  logic       CLK_50,
  input  logic       RESET_N,
  input  logic       CAM_READY,
  input  logic       STEP_REQ,
  input  logic [9:0] STEP,
  output logic       I2C_SCL,
  inout  wire        I2C_SDA,
  output logic       VCM_RELAESE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_ERR,
  output logic [2:0] dbg_state
);
  localparam int DW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [1:0]    byte_cnt, byte_cnt_nx;
  logic [9:0]    step_q;
  logic [7:0]    cur_byte;
  logic          scl_d, sda_low_d, sda_low_q, sda_in;
  logic          q, seg_end, accept, ack_sample;

  // Handshake: STEP_REQ is a one-cycle request with no ready; it is taken only
  // when idle, CAM_READY is high and DONE is not pulsing, otherwise it is lost.
  // BUSY marks accept..end of frame, DONE pulses once per frame (OK or NACK).
  assign accept     = STEP_REQ && CAM_READY && (state == S_IDLE) && !DONE;
  assign q          = (state != S_IDLE) && (div_cnt == DW'(CLK_DIV - 1));
  assign seg_end    = q && (phase == 2'd3);
  assign ack_sample = q && (state == S_ACK) && (phase == 2'd2);
  assign sda_in     = I2C_SDA;
  assign I2C_SDA    = sda_low_q ? 1'b0 : 1'bz;
  assign dbg_state  = state;

  always_comb begin
    case (byte_cnt)
      2'd0:    cur_byte = {VCM_ADDR, 1'b0};
      2'd1:    cur_byte = {2'b00, step_q[9:4]};
      default: cur_byte = {step_q[3:0], SLEW};
    endcase
  end

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    byte_cnt_nx = byte_cnt;
    case (state)
      S_IDLE:
        if (accept) begin
          state_nx    = S_START;
          bit_cnt_nx  = 3'd7;
          byte_cnt_nx = 2'd0;
        end
      S_START:
        if (seg_end) state_nx = S_BIT;
      S_BIT:
        if (seg_end) begin
          if (bit_cnt == 3'd0) state_nx = S_ACK;
          else bit_cnt_nx = bit_cnt - 3'd1;
        end
      S_ACK:
        // ACK_ERR was cleared at accept, so here it only reflects this frame
        if (seg_end) begin
          if (ACK_ERR || byte_cnt == 2'd2) begin
            state_nx = S_STOP;
          end else begin
            state_nx    = S_BIT;
            bit_cnt_nx  = 3'd7;
            byte_cnt_nx = byte_cnt + 2'd1;
          end
        end
      S_STOP:
        if (seg_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state)
      S_START: begin
        scl_d     = (phase != 2'd3);
        sda_low_d = (phase != 2'd0);
      end
      S_BIT: begin
        scl_d     = (phase == 2'd1) || (phase == 2'd2);
        sda_low_d = !cur_byte[bit_cnt];
      end
      S_ACK: scl_d = (phase == 2'd1) || (phase == 2'd2);
      S_STOP: begin
        scl_d     = (phase != 2'd0);
        sda_low_d = (phase == 2'd0) || (phase == 2'd1);
      end
      default: ;
    endcase
  end

  // Bus pins are registered so SCL/SDA never glitch on state decode.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      phase       <= 2'd0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 2'd0;
      step_q      <= 10'd0;
      BUSY        <= 1'b0;
      VCM_RELAESE <= 1'b1;
      DONE        <= 1'b0;
      ACK_ERR     <= 1'b0;
      I2C_SCL     <= 1'b1;
      sda_low_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      byte_cnt  <= byte_cnt_nx;
      DONE      <= 1'b0;
      I2C_SCL   <= scl_d;
      sda_low_q <= sda_low_d;
      if (accept) begin
        step_q      <= STEP;
        ACK_ERR     <= 1'b0;
        BUSY        <= 1'b1;
        VCM_RELAESE <= 1'b0;
        div_cnt     <= '0;
        phase       <= 2'd0;
      end else if (state != S_IDLE) begin
        div_cnt <= q ? '0 : div_cnt + 1'b1;
        if (q) phase <= phase + 2'd1;
        if (ack_sample && sda_in) ACK_ERR <= 1'b1;
        if (seg_end && state == S_STOP) begin
          DONE        <= 1'b1;
          BUSY        <= 1'b0;
          VCM_RELAESE <= 1'b1;
        end
      end
    end
  end
endmodule
